// File: rtl/mgmt_read_responder_if.sv
// Management read bus: command/stream side driven by the bridge, plus the fabric RAM write port.
interface mgmt_read_responder_if #(parameter int ADDR_BITS = 8);
  logic                 rd_en;
  logic [15:0]          rd_addr;
  logic [15:0]          rd_len;
  logic                 rd_valid;
  logic [7:0]           rd_data;
  logic                 busy;
  logic                 rd_overrun;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;

  modport master (
    output rd_en, rd_addr, rd_len, wr_en, wr_addr, wr_data,
    input  rd_valid, rd_data, busy, rd_overrun
  );

  modport slave (
    input  rd_en, rd_addr, rd_len, wr_en, wr_addr, wr_data,
    output rd_valid, rd_data, busy, rd_overrun
  );
endinterface

// File: rtl/mgmt_read_responder.sv
// Far-end management read responder: streams rd_len bytes from a byte RAM starting at rd_addr,
// one byte per clock, two cycles after the command.
module mgmt_read_responder #(
  parameter  int DEPTH     = 256,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  mgmt_read_responder_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state, state_d;
  logic [15:0] cur, cur_d;
  logic [16:0] rem, rem_d;
  logic        issue, accept, oor;

  logic [7:0]  ram [DEPTH];
  logic [7:0]  ram_q;
  logic        oor_q;
  logic [1:0]  vld_pipe;
  logic [7:0]  rd_data_q;
  logic        busy_q, overrun_q;

  assign accept = bus.rd_en && (state == IDLE) && !busy_q;
  // Full 16-bit compare so addresses past the RAM never alias onto the low bits.
  assign oor    = {1'b0, cur} >= 17'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      rem   <= '0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      rem   <= rem_d;
    end
  end

  always_comb begin
    state_d = state;
    cur_d   = cur;
    rem_d   = rem;
    issue   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        cur_d   = bus.rd_addr;
        rem_d   = (bus.rd_len == 16'd0) ? 17'd1 : {1'b0, bus.rd_len};
        state_d = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        cur_d = cur + 16'd1;
        rem_d = rem - 17'd1;
        if (rem == 17'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read and write share the edge: the read sees the pre-write byte (read-first).
  always_ff @(posedge clk) begin
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    if (issue) begin
      ram_q <= ram[cur[ADDR_BITS-1:0]];
      oor_q <= oor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      if (vld_pipe[0]) rd_data_q <= oor_q ? 8'h00 : ram_q;
      // Stays high until the final byte has left the read stage.
      busy_q <= (state == ISSUE) || vld_pipe[0];
      if (bus.rd_en && !accept) overrun_q <= 1'b1;
    end
  end

  assign bus.rd_valid   = vld_pipe[1];
  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = busy_q;
  assign bus.rd_overrun = overrun_q;
endmodule

// File: tb/tb_mgmt_read_responder.sv
// Self-checking bench for mgmt_read_responder: directed scenarios plus randomized reads against a byte-array model.
module tb_mgmt_read_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mgmt_read_responder_if #(.ADDR_BITS(8)) bus();
  mgmt_read_responder #(.DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mem [256];
  logic       v_log [4096];
  logic [7:0] d_log [4096];
  logic       b_log [4096];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    v_log[cyc & 4095] = bus.rd_valid;
    d_log[cyc & 4095] = bus.rd_data;
    b_log[cyc & 4095] = bus.busy;
  end

  function automatic logic [7:0] model_byte(input int a);
    return (a < 256) ? mem[a] : 8'h00;
  endfunction

  function automatic int eff_len(input logic [15:0] l);
    return (l == 16'd0) ? 1 : int'(l);
  endfunction

  task automatic load_ram(input bit ramp);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'(i);
      bus.wr_data = ramp ? 8'(i) : 8'($urandom);
      mem[i]      = bus.wr_data;
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy !== 1'b0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL wait_idle: busy=%b still set after %0d cycles, required 0", bus.busy, t);
    end
  endtask

  // Returns n = edge index at which the command was sampled.
  task automatic send_cmd(input logic [15:0] a, input logic [15:0] l, output int n);
    wait_idle();
    @(posedge clk); #1;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    bus.rd_len  = l;
    @(posedge clk); #1;
    n = cyc;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_transfer(input string name, input logic [15:0] a, input logic [15:0] l);
    int n, len, k;
    logic [7:0] e;
    send_cmd(a, l, n);
    len = eff_len(l);
    repeat (len + 4) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (v_log[(n+1) & 4095] !== 1'b0 || b_log[(n+1) & 4095] !== 1'b1) begin
      errors++;
      $display("FAIL %s lead: valid=%b busy=%b at N+1, required valid=0 busy=1",
               name, v_log[(n+1) & 4095], b_log[(n+1) & 4095]);
    end
    for (int i = 0; i < len; i++) begin
      k = (n + 2 + i) & 4095;
      e = model_byte((int'(a) + i) & 32'hFFFF);
      checks++;
      if (v_log[k] !== 1'b1 || d_log[k] !== e || b_log[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s byte%0d: valid=%b data=%h busy=%b, required valid=1 data=%h busy=1",
                 name, i, v_log[k], d_log[k], b_log[k], e);
      end
    end
    k = (n + 2 + len) & 4095;
    checks++;
    if (v_log[k] !== 1'b0 || b_log[k] !== 1'b0 || v_log[(k + 1) & 4095] !== 1'b0) begin
      errors++;
      $display("FAIL %s tail: valid=%b busy=%b next_valid=%b, required 0 0 0",
               name, v_log[k], b_log[k], v_log[(k + 1) & 4095]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({bus.rd_valid, bus.rd_data, bus.busy, bus.rd_overrun} !== 11'h0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b data=%h busy=%b ovr=%b, required all 0",
               bus.rd_valid, bus.rd_data, bus.busy, bus.rd_overrun);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({bus.rd_valid, bus.busy, bus.rd_overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: valid=%b busy=%b ovr=%b, required 0 0 0",
               bus.rd_valid, bus.busy, bus.rd_overrun);
    end
  endtask

  task automatic test_basic();
    test_transfer("basic_10_4", 16'h0010, 16'd4);
  endtask

  task automatic test_range();
    test_transfer("range_fe_4", 16'h00FE, 16'd4);
    test_transfer("range_ffff_2", 16'hFFFF, 16'd2);
    test_transfer("range_high", 16'h8000, 16'd3);
  endtask

  task automatic test_len0();
    test_transfer("len0_05", 16'h0005, 16'd0);
  endtask

  task automatic test_overrun();
    int n, k;
    checks++;
    if (bus.rd_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: ovr=%b, required 0", bus.rd_overrun);
    end
    send_cmd(16'h0020, 16'd4, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 16'h0080;
    bus.rd_len  = 16'd9;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      k = (n + 2 + i) & 4095;
      checks++;
      if (v_log[k] !== 1'b1 || d_log[k] !== model_byte(32 + i)) begin
        errors++;
        $display("FAIL overrun_byte%0d: valid=%b data=%h, required valid=1 data=%h",
                 i, v_log[k], d_log[k], model_byte(32 + i));
      end
    end
    for (int i = 6; i < 16; i++) begin
      k = (n + i) & 4095;
      checks++;
      if (v_log[k] !== 1'b0 || b_log[k] !== 1'b0) begin
        errors++;
        $display("FAIL overrun_extra N+%0d: valid=%b busy=%b, required 0 0", i, v_log[k], b_log[k]);
      end
    end
    checks++;
    if (bus.rd_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: ovr=%b, required 1", bus.rd_overrun);
    end
  endtask

  task automatic test_rw_collision();
    int n;
    logic [7:0] old;
    old = mem[8'h12];
    send_cmd(16'h0010, 16'd4, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'h12;
    bus.wr_data = 8'hAA;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (v_log[(n + 4) & 4095] !== 1'b1 || d_log[(n + 4) & 4095] !== old) begin
      errors++;
      $display("FAIL collision_old: valid=%b data=%h, required valid=1 data=%h",
               v_log[(n + 4) & 4095], d_log[(n + 4) & 4095], old);
    end
    mem[8'h12] = 8'hAA;
    test_transfer("collision_reread", 16'h0012, 16'd1);
  endtask

  task automatic test_async_reset();
    int n;
    send_cmd(16'h0040, 16'd8, n);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_overrun !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: valid=%b ovr=%b, required 1 1", bus.rd_valid, bus.rd_overrun);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rd_valid, bus.busy, bus.rd_overrun} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b ovr=%b, required 0 0 0",
               bus.rd_valid, bus.busy, bus.rd_overrun);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL async_after%0d: valid=%b busy=%b, required 0 0", i, bus.rd_valid, bus.busy);
      end
    end
    test_transfer("async_reread", 16'h0040, 16'd8);
  endtask

  task automatic test_random();
    logic [15:0] a, l;
    logic [7:0]  wa;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        wa          = 8'($urandom);
        bus.wr_en   = 1'b1;
        bus.wr_addr = wa;
        bus.wr_data = 8'($urandom);
        mem[wa]     = bus.wr_data;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
      end
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 255));
        1:       a = 16'($urandom_range(16'h00F0, 16'h0110));
        2:       a = 16'($urandom_range(16'hFFF4, 16'hFFFF));
        default: a = 16'($urandom);
      endcase
      l = 16'($urandom_range(0, 12));
      test_transfer("random", a, l);
    end
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.rd_len  = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    load_ram(1'b1);
    test_basic();
    test_range();
    test_len0();
    test_overrun();
    test_rw_collision();
    test_async_reset();
    load_ram(1'b0);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
